// File: rtl/gpu_pkg.sv
// Shared GPU definitions used by the frame double-buffer controller.
//   frame_swap_state_t : controller sequencing states
//   frame_idx_t        : index of one of the two SDRAM frames
//   FRAME_RESET_DRAW   : frame the rasterizer writes after reset
package gpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RENDER,
    WAIT_VB,
    SWAP
  } frame_swap_state_t;

  typedef logic frame_idx_t;

  localparam frame_idx_t FRAME_RESET_DRAW = 1'b1;

endpackage

// File: rtl/cycle_timer.sv
// Up-counting watchdog timer.
//   clk, reset : clock and synchronous active-high reset
//   clear      : restart the count from zero (has priority over en)
//   en         : advance the count by one this cycle
//   limit      : count value at which the timer reports expiry
//   expired    : high while the count equals limit
// The count holds at limit so a lingering enable cannot wrap it
// back to a non-expired value.
module cycle_timer #(
  parameter int unsigned CNT_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expired = (cnt_q == limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/frame_swap_ctrl.sv
// Double-buffer controller for the two SDRAM frames. Accepts host render
// requests, runs the optional back-frame clear and the rasterizer, then
// swaps the front/back frame indices during vertical blanking.
//
// Ports
//   clk, reset    : clock, synchronous active-high reset
//   shape_req     : host request level, held until shape_ack
//   shape_ack     : one-cycle pulse, request accepted
//   clear_start   : one-cycle pulse to the clear engine
//   clear_done    : one-cycle pulse, back frame cleared
//   render_start  : one-cycle pulse to the rasterizer
//   render_done   : one-cycle pulse, shape drawn
//   vblank        : display vertical blanking level
//   draw_frame    : back frame index (written by clear/raster engines)
//   disp_frame    : front frame index (read by display), ~draw_frame
//   swap_pulse    : one-cycle pulse while the swap is taking place
//   busy          : high in every state except IDLE
//   err           : sticky timeout flag, cleared only by reset
//   frame_cnt     : completed swap count, wraps at 256
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for shape_req
// CLEAR   | clear engine running on the back frame, watchdog armed
// RENDER  | rasterizer running on the back frame, watchdog armed
// WAIT_VB | frame complete, waiting for vertical blanking
// SWAP    | one cycle; indices and frame_cnt update at its closing edge
module frame_swap_ctrl
  import gpu_pkg::*;
#(
  parameter bit          CLEAR_EN       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned CNT_W          = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       shape_req,
  output logic       shape_ack,
  output logic       clear_start,
  input  logic       clear_done,
  output logic       render_start,
  input  logic       render_done,
  input  logic       vblank,
  output logic       draw_frame,
  output logic       disp_frame,
  output logic       swap_pulse,
  output logic       busy,
  output logic       err,
  output logic [7:0] frame_cnt
);

  // The timer reads 0 on the first cycle of a watched state, so the
  // final allowed cycle is the one where it reads TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  frame_swap_state_t state_q;
  frame_swap_state_t state_d;

  logic       shape_ack_q,    shape_ack_d;
  logic       clear_start_q,  clear_start_d;
  logic       render_start_q, render_start_d;
  logic       swap_pulse_q,   swap_pulse_d;
  logic       busy_q,         busy_d;
  logic       err_q,          err_d;
  frame_idx_t draw_frame_q,   draw_frame_d;
  frame_idx_t disp_frame_q,   disp_frame_d;
  logic [7:0] frame_cnt_q,    frame_cnt_d;

  logic tmr_clear;
  logic tmr_en;
  logic tmr_expired;

  assign tmr_en = (state_q == CLEAR) || (state_q == RENDER);

  cycle_timer #(
    .CNT_W (CNT_W)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .en      (tmr_en),
    .limit   (TMO_LIMIT),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d        = state_q;
    shape_ack_d    = 1'b0;
    clear_start_d  = 1'b0;
    render_start_d = 1'b0;
    swap_pulse_d   = 1'b0;
    err_d          = err_q;
    draw_frame_d   = draw_frame_q;
    disp_frame_d   = disp_frame_q;
    frame_cnt_d    = frame_cnt_q;
    tmr_clear      = 1'b0;

    case (state_q)
      IDLE: begin
        if (shape_req) begin
          shape_ack_d = 1'b1;
          tmr_clear   = 1'b1;
          if (CLEAR_EN) begin
            clear_start_d = 1'b1;
            state_d       = CLEAR;
          end else begin
            render_start_d = 1'b1;
            state_d        = RENDER;
          end
        end
      end

      // A done arriving on the expiry cycle still counts as success.
      CLEAR: begin
        if (clear_done) begin
          render_start_d = 1'b1;
          tmr_clear      = 1'b1;
          state_d        = RENDER;
        end else if (tmr_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      RENDER: begin
        if (render_done) begin
          state_d = WAIT_VB;
        end else if (tmr_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      // Level sensitive: vblank already high moves straight on.
      WAIT_VB: begin
        if (vblank) begin
          swap_pulse_d = 1'b1;
          state_d      = SWAP;
        end
      end

      // Indices flip at the edge that leaves SWAP, so draw and display
      // are never pointed at the same frame.
      SWAP: begin
        draw_frame_d = ~draw_frame_q;
        disp_frame_d = ~disp_frame_q;
        frame_cnt_d  = frame_cnt_q + 8'd1;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      shape_ack_q    <= 1'b0;
      clear_start_q  <= 1'b0;
      render_start_q <= 1'b0;
      swap_pulse_q   <= 1'b0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
      draw_frame_q   <= FRAME_RESET_DRAW;
      disp_frame_q   <= ~FRAME_RESET_DRAW;
      frame_cnt_q    <= 8'd0;
    end else begin
      state_q        <= state_d;
      shape_ack_q    <= shape_ack_d;
      clear_start_q  <= clear_start_d;
      render_start_q <= render_start_d;
      swap_pulse_q   <= swap_pulse_d;
      busy_q         <= busy_d;
      err_q          <= err_d;
      draw_frame_q   <= draw_frame_d;
      disp_frame_q   <= disp_frame_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end

  assign shape_ack    = shape_ack_q;
  assign clear_start  = clear_start_q;
  assign render_start = render_start_q;
  assign swap_pulse   = swap_pulse_q;
  assign busy         = busy_q;
  assign err          = err_q;
  assign draw_frame   = draw_frame_q;
  assign disp_frame   = disp_frame_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_frame_swap_ctrl.sv
// Bench for frame_swap_ctrl. Instance "a" uses the clear phase with a
// short timeout; instance "b" skips the clear phase. Expected pulse
// cycles and frame state are computed per job from the delays chosen.
module tb_frame_swap_ctrl;

  localparam int TMO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       shape_req, clear_done, render_done, vblank;
  logic       shape_ack, clear_start, render_start, swap_pulse, busy, err;
  logic       draw_frame, disp_frame;
  logic [7:0] frame_cnt;

  logic       req_b, cdone_b, rdone_b, vblank_b;
  logic       ack_b, cstart_b, rstart_b, swap_b, busy_b, err_b;
  logic       draw_b, disp_b;
  logic [7:0] cnt_b;

  frame_swap_ctrl #(.CLEAR_EN(1'b1), .TIMEOUT_CYCLES(TMO), .CNT_W(5)) dut_a (
    .clk(clk), .reset(reset), .shape_req(shape_req), .shape_ack(shape_ack),
    .clear_start(clear_start), .clear_done(clear_done),
    .render_start(render_start), .render_done(render_done), .vblank(vblank),
    .draw_frame(draw_frame), .disp_frame(disp_frame), .swap_pulse(swap_pulse),
    .busy(busy), .err(err), .frame_cnt(frame_cnt)
  );

  frame_swap_ctrl #(.CLEAR_EN(1'b0), .TIMEOUT_CYCLES(TMO), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .shape_req(req_b), .shape_ack(ack_b),
    .clear_start(cstart_b), .clear_done(cdone_b),
    .render_start(rstart_b), .render_done(rdone_b), .vblank(vblank_b),
    .draw_frame(draw_b), .disp_frame(disp_b), .swap_pulse(swap_b),
    .busy(busy_b), .err(err_b), .frame_cnt(cnt_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // reference frame state for instance a
  logic       m_draw;
  logic [7:0] m_cnt;
  logic       m_err;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_all(input bit e_ack, input bit e_cs, input bit e_rs,
                         input bit e_sw, input bit e_busy);
    logic nd;
    nd = ~m_draw;
    chk("shape_ack", shape_ack, e_ack);
    chk("clear_start", clear_start, e_cs);
    chk("render_start", render_start, e_rs);
    chk("swap_pulse", swap_pulse, e_sw);
    chk("busy", busy, e_busy);
    chk("err", err, m_err);
    chk("draw_frame", draw_frame, m_draw);
    chk("disp_frame", disp_frame, nd);
    chk("frame_cnt", frame_cnt, m_cnt);
  endtask

  // One request on instance a. dc/dr: cycles from clear_start/render_start
  // to the done pulse (>= TMO means it never comes). vbd: WAIT_VB cycles
  // before vblank rises (0 = already high). pend: raise a second request
  // during RENDER and hold it past the end of the job.
  task automatic run_job(input int dc, input int dr, input int vbd, input bit pend);
    int t, cs, rs, wv, vr, sw, fin;
    bit tmo;
    t = cyc; cs = t + 1; rs = -1; wv = -1; vr = -1; sw = -1; tmo = 1'b0;
    if (dc >= TMO) begin
      tmo = 1'b1; fin = cs + TMO;
    end else begin
      rs = cs + dc + 1;
      if (dr >= TMO) begin
        tmo = 1'b1; fin = rs + TMO;
      end else begin
        wv = rs + dr + 1; vr = wv + vbd; sw = vr + 1; fin = sw + 1;
      end
    end
    shape_req = 1'b1; clear_done = 1'b0; render_done = 1'b0;
    vblank = (vbd == 0);
    for (int c = t + 1; c <= fin; c++) begin
      tick();
      if (c == fin) begin
        if (sw > 0) begin
          m_draw = ~m_draw;
          m_cnt  = m_cnt + 8'd1;
        end
        if (tmo) m_err = 1'b1;
      end
      chk_all(c == cs, c == cs, c == rs, c == sw, c < fin);
      shape_req   = pend && (rs > 0) && (c >= rs);
      clear_done  = (rs > 0) && ((c == rs - 1) || (c == rs));
      render_done = (c == cs) || ((wv > 0) && (c == wv - 1)) ||
                    ((wv > 0) && (vbd > 0) && (c == wv));
      vblank      = (vbd == 0) || ((vr > 0) && (c >= vr));
    end
    shape_req = pend; clear_done = 1'b0; render_done = 1'b0;
  endtask

  initial begin
    int t;
    reset = 1'b1; shape_req = 1'b0; clear_done = 1'b0; render_done = 1'b0;
    vblank = 1'b0;
    req_b = 1'b0; cdone_b = 1'b0; rdone_b = 1'b0; vblank_b = 1'b1;
    m_draw = 1'b1; m_cnt = 8'd0; m_err = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all(0, 0, 0, 0, 0);
    end

    // instance b: no clear phase, minimum request-to-swap latency
    chk("b_draw_reset", draw_b, 1);
    chk("b_busy_reset", busy_b, 0);
    t = cyc;
    req_b = 1'b1;
    tick();
    chk("b_ack", ack_b, 1);
    chk("b_render_start", rstart_b, 1);
    chk("b_clear_start", cstart_b, 0);
    req_b = 1'b0;
    tick();
    chk("b_render_start_once", rstart_b, 0);
    rdone_b = 1'b1;
    tick();
    rdone_b = 1'b0;
    chk("b_swap_early", swap_b, 0);
    chk("b_busy", busy_b, 1);
    tick();
    chk("b_swap_cycle", cyc - t, 4);
    chk("b_swap", swap_b, 1);
    tick();
    chk("b_draw", draw_b, 0);
    chk("b_disp", disp_b, 1);
    chk("b_cnt", cnt_b, 1);
    chk("b_busy_done", busy_b, 0);
    chk("b_err", err_b, 0);

    // instance a directed cases
    run_job(5, 8, 0, 1'b0);
    run_job(2, 3, 20, 1'b0);
    run_job(TMO - 1, TMO - 1, 0, 1'b0);
    run_job(1, 4, 2, 1'b1);
    run_job(0, 2, 0, 1'b0);
    run_job(2, 99, 0, 1'b0);
    run_job(1, 1, 0, 1'b0);
    run_job(99, 0, 0, 1'b0);
    run_job(0, 0, 1, 1'b0);

    for (int i = 0; i < 30; i++) begin
      run_job(int'($urandom_range(0, TMO + 1)), int'($urandom_range(0, TMO + 1)),
              int'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0));
    end

    // reset while rendering abandons the job and restores reset values
    t = cyc;
    shape_req = 1'b1;
    tick();
    chk("rst_ack", shape_ack, 1);
    shape_req = 1'b0; clear_done = 1'b1;
    tick();
    clear_done = 1'b0;
    chk("rst_render_start", render_start, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_draw = 1'b1; m_cnt = 8'd0; m_err = 1'b0;
    chk_all(0, 0, 0, 0, 0);
    render_done = 1'b1;
    tick();
    render_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all(0, 0, 0, 0, 0);
    end

    // 256 swaps from zero wrap the counter back to zero
    for (int i = 0; i < 256; i++) begin
      run_job(0, 0, int'($urandom_range(0, 1)), 1'b0);
    end
    chk("frame_cnt_wrap", frame_cnt, 0);
    chk("draw_after_wrap", draw_frame, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
